// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between the IF/ID and ID/EX boundaries.
// The incoming instruction is decoded combinationally and registered, so the
// result appears one cycle after it is accepted. Control encodings follow the
// define.vh set, with every *_X code equal to 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready is combinational
//   in_inst, in_pc       fetched instruction and its pc
//   flush                kill the registered instruction and drop the input
//   out_valid/out_ready  downstream handshake
//   out_pc, out_imm      registered pc and sign-extended immediate
//   out_rs1/rs2/rd_addr  register addresses
//   out_exe_fun          ALU_*/BR_* code
//   out_rs1_sel          RS1_* code
//   out_rs2_sel          RS2_* code
//   out_mem_wen          MEN_S for stores
//   out_rf_wen           REN_S when rd is written
//   out_wb_sel           WB_* code
//   out_mem_size         0 byte, 1 half, 2 word
//   out_mem_unsigned     set for LBU/LHU
//   out_illegal          undefined encoding
module decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [4:0]      out_rd_addr,
    output logic [4:0]      out_exe_fun,
    output logic [1:0]      out_rs1_sel,
    output logic [2:0]      out_rs2_sel,
    output logic            out_mem_wen,
    output logic            out_rf_wen,
    output logic [1:0]      out_wb_sel,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_illegal
);

    // Control encodings (define.vh)
    localparam logic [4:0] ALU_X    = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] BR_BEQ   = 5'd11;
    localparam logic [4:0] BR_BNE   = 5'd12;
    localparam logic [4:0] BR_BLT   = 5'd13;
    localparam logic [4:0] BR_BGE   = 5'd14;
    localparam logic [4:0] BR_BLTU  = 5'd15;
    localparam logic [4:0] BR_BGEU  = 5'd16;
    localparam logic [4:0] ALU_JALR = 5'd17;

    localparam logic [1:0] RS1_X   = 2'd0;
    localparam logic [1:0] RS1_RS1 = 2'd1;
    localparam logic [1:0] RS1_PC  = 2'd2;

    localparam logic [2:0] RS2_X   = 3'd0;
    localparam logic [2:0] RS2_RS2 = 3'd1;
    localparam logic [2:0] RS2_IMI = 3'd2;
    localparam logic [2:0] RS2_IMS = 3'd3;
    localparam logic [2:0] RS2_IMJ = 3'd4;
    localparam logic [2:0] RS2_IMU = 3'd5;

    localparam logic MEN_S = 1'b1;
    localparam logic REN_S = 1'b1;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];

    // Immediate formats, all sign-extended from bit 31
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    logic [31:0] d_imm;
    logic [4:0]  d_exe_fun;
    logic [1:0]  d_rs1_sel;
    logic [2:0]  d_rs2_sel;
    logic        d_mem_wen;
    logic        d_rf_wen;
    logic [1:0]  d_wb_sel;
    logic [1:0]  d_mem_size;
    logic        d_mem_unsigned;
    logic        d_illegal;

    // Combinational instruction decode; illegal encodings collapse to *_X
    always_comb begin
        d_imm          = 32'd0;
        d_exe_fun      = ALU_X;
        d_rs1_sel      = RS1_X;
        d_rs2_sel      = RS2_X;
        d_mem_wen      = 1'b0;
        d_rf_wen       = 1'b0;
        d_wb_sel       = WB_X;
        d_mem_size     = 2'd0;
        d_mem_unsigned = 1'b0;
        d_illegal      = 1'b0;

        case (opcode)
            OPC_LUI: begin
                d_imm = imm_u; d_exe_fun = ALU_ADD; d_rs2_sel = RS2_IMU;
                d_rf_wen = REN_S; d_wb_sel = WB_ALU;
            end
            OPC_AUIPC: begin
                d_imm = imm_u; d_exe_fun = ALU_ADD; d_rs1_sel = RS1_PC; d_rs2_sel = RS2_IMU;
                d_rf_wen = REN_S; d_wb_sel = WB_ALU;
            end
            OPC_JAL: begin
                d_imm = imm_j; d_exe_fun = ALU_ADD; d_rs1_sel = RS1_PC; d_rs2_sel = RS2_IMJ;
                d_rf_wen = REN_S; d_wb_sel = WB_PC;
            end
            OPC_JALR: begin
                d_imm = imm_i; d_exe_fun = ALU_JALR; d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_IMI;
                d_rf_wen = REN_S; d_wb_sel = WB_PC;
                d_illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_imm = imm_b; d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_RS2;
                case (funct3)
                    3'b000:  d_exe_fun = BR_BEQ;
                    3'b001:  d_exe_fun = BR_BNE;
                    3'b100:  d_exe_fun = BR_BLT;
                    3'b101:  d_exe_fun = BR_BGE;
                    3'b110:  d_exe_fun = BR_BLTU;
                    3'b111:  d_exe_fun = BR_BGEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_imm = imm_i; d_exe_fun = ALU_ADD; d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_IMI;
                d_rf_wen = REN_S; d_wb_sel = WB_MEM;
                case (funct3)
                    3'b000:  d_mem_size = 2'd0;
                    3'b001:  d_mem_size = 2'd1;
                    3'b010:  d_mem_size = 2'd2;
                    3'b100:  begin d_mem_size = 2'd0; d_mem_unsigned = 1'b1; end
                    3'b101:  begin d_mem_size = 2'd1; d_mem_unsigned = 1'b1; end
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_imm = imm_s; d_exe_fun = ALU_ADD; d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_IMS;
                d_mem_wen = MEN_S;
                case (funct3)
                    3'b000:  d_mem_size = 2'd0;
                    3'b001:  d_mem_size = 2'd1;
                    3'b010:  d_mem_size = 2'd2;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                d_imm = imm_i; d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_IMI;
                d_rf_wen = REN_S; d_wb_sel = WB_ALU;
                case (funct3)
                    3'b000: d_exe_fun = ALU_ADD;
                    3'b010: d_exe_fun = ALU_SLT;
                    3'b011: d_exe_fun = ALU_SLTU;
                    3'b100: d_exe_fun = ALU_XOR;
                    3'b110: d_exe_fun = ALU_OR;
                    3'b111: d_exe_fun = ALU_AND;
                    3'b001: begin
                        d_exe_fun = ALU_SLL;
                        d_illegal = (funct7 != F7_ZERO);
                    end
                    default: begin
                        if (funct7 == F7_ZERO)     d_exe_fun = ALU_SRL;
                        else if (funct7 == F7_ALT) d_exe_fun = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d_rs1_sel = RS1_RS1; d_rs2_sel = RS2_RS2;
                d_rf_wen = REN_S; d_wb_sel = WB_ALU;
                if (funct7 == F7_ZERO) begin
                    case (funct3)
                        3'b000:  d_exe_fun = ALU_ADD;
                        3'b001:  d_exe_fun = ALU_SLL;
                        3'b010:  d_exe_fun = ALU_SLT;
                        3'b011:  d_exe_fun = ALU_SLTU;
                        3'b100:  d_exe_fun = ALU_XOR;
                        3'b101:  d_exe_fun = ALU_SRL;
                        3'b110:  d_exe_fun = ALU_OR;
                        default: d_exe_fun = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    d_exe_fun = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    d_exe_fun = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_FENCE: ;  // legal no-op, all controls stay *_X
            default: d_illegal = 1'b1;
        endcase

        if (d_illegal) begin
            d_imm          = 32'd0;
            d_exe_fun      = ALU_X;
            d_rs1_sel      = RS1_X;
            d_rs2_sel      = RS2_X;
            d_mem_wen      = 1'b0;
            d_rf_wen       = 1'b0;
            d_wb_sel       = WB_X;
            d_mem_size     = 2'd0;
            d_mem_unsigned = 1'b0;
        end
    end

    // Source-register usage is a property of the opcode alone
    logic uses_rs1;
    logic uses_rs2;
    assign uses_rs1 = (opcode == OPC_JALR) || (opcode == OPC_BRANCH) || (opcode == OPC_LOAD) ||
                      (opcode == OPC_STORE) || (opcode == OPC_OPIMM) || (opcode == OPC_OP);
    assign uses_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);

    // Loads are the only instructions that write back from memory
    logic load_en;
    logic hazard;
    assign load_en = ~out_valid | out_ready;
    assign hazard  = HAZARD_EN && out_valid && (out_wb_sel == WB_MEM) && (out_rd_addr != 5'd0) &&
                     in_valid && ((uses_rs1 && rs1 == out_rd_addr) || (uses_rs2 && rs2 == out_rd_addr));
    assign in_ready = load_en & ~hazard & ~flush;

    // Flush and bubbles both load a zeroed, invalid slot
    logic upd;
    logic take;
    assign upd  = flush | load_en;
    assign take = in_ready & in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_pc           <= '0;
            out_imm          <= '0;
            out_rs1_addr     <= 5'd0;
            out_rs2_addr     <= 5'd0;
            out_rd_addr      <= 5'd0;
            out_exe_fun      <= ALU_X;
            out_rs1_sel      <= RS1_X;
            out_rs2_sel      <= RS2_X;
            out_mem_wen      <= 1'b0;
            out_rf_wen       <= 1'b0;
            out_wb_sel       <= WB_X;
            out_mem_size     <= 2'd0;
            out_mem_unsigned <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (upd) begin
            out_valid        <= take;
            out_pc           <= take ? in_pc : '0;
            out_imm          <= take ? XLEN'(signed'(d_imm)) : '0;
            out_rs1_addr     <= take ? rs1 : 5'd0;
            out_rs2_addr     <= take ? rs2 : 5'd0;
            out_rd_addr      <= take ? rd : 5'd0;
            out_exe_fun      <= take ? d_exe_fun : ALU_X;
            out_rs1_sel      <= take ? d_rs1_sel : RS1_X;
            out_rs2_sel      <= take ? d_rs2_sel : RS2_X;
            out_mem_wen      <= take & d_mem_wen;
            out_rf_wen       <= take & d_rf_wen;
            out_wb_sel       <= take ? d_wb_sel : WB_X;
            out_mem_size     <= take ? d_mem_size : 2'd0;
            out_mem_unsigned <= take & d_mem_unsigned;
            out_illegal      <= take & d_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. One instance has the
// load-use interlock enabled, a second has it disabled; they share every
// input except in_valid.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_valid_b;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_mem_wen, out_rf_wen, out_mem_unsigned, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr, out_exe_fun;
    logic [1:0]  out_rs1_sel, out_wb_sel, out_mem_size;
    logic [2:0]  out_rs2_sel;

    logic        in_ready_b, out_valid_b, out_mem_wen_b, out_rf_wen_b, out_mem_unsigned_b, out_illegal_b;
    logic [31:0] out_pc_b, out_imm_b;
    logic [4:0]  out_rs1_addr_b, out_rs2_addr_b, out_rd_addr_b, out_exe_fun_b;
    logic [1:0]  out_rs1_sel_b, out_wb_sel_b, out_mem_size_b;
    logic [2:0]  out_rs2_sel_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_exe_fun(out_exe_fun), .out_rs1_sel(out_rs1_sel), .out_rs2_sel(out_rs2_sel),
        .out_mem_wen(out_mem_wen), .out_rf_wen(out_rf_wen), .out_wb_sel(out_wb_sel),
        .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b0)) dut_nohaz (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_imm(out_imm_b),
        .out_rs1_addr(out_rs1_addr_b), .out_rs2_addr(out_rs2_addr_b), .out_rd_addr(out_rd_addr_b),
        .out_exe_fun(out_exe_fun_b), .out_rs1_sel(out_rs1_sel_b), .out_rs2_sel(out_rs2_sel_b),
        .out_mem_wen(out_mem_wen_b), .out_rf_wen(out_rf_wen_b), .out_wb_sel(out_wb_sel_b),
        .out_mem_size(out_mem_size_b), .out_mem_unsigned(out_mem_unsigned_b), .out_illegal(out_illegal_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational in_ready settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_imm", out_imm, 32'd0);
        check("rst_exe", 32'(out_exe_fun), 32'd0);
        check("rst_ctrl", {26'd0, out_rf_wen, out_mem_wen, out_wb_sel, out_illegal, out_mem_unsigned}, 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5
        send(32'h00500093, 32'h100);
        settle();
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_exe", 32'(out_exe_fun), 32'd1);
        check("addi_rs1_sel", 32'(out_rs1_sel), 32'd1);
        check("addi_rs2_sel", 32'(out_rs2_sel), 32'd2);
        check("addi_rf_wen", 32'(out_rf_wen), 32'd1);
        check("addi_rd", 32'(out_rd_addr), 32'd1);
        check("addi_illegal", 32'(out_illegal), 32'd0);
        check("addi_pc", out_pc, 32'h100);

        // LW x2,0(x1) followed by dependent ADD x3,x2,x1
        send(32'h0000A103, 32'h104);
        tick();
        check("lw_wb", 32'(out_wb_sel), 32'd2);
        check("lw_size", 32'(out_mem_size), 32'd2);
        check("lw_rd", 32'(out_rd_addr), 32'd2);
        send(32'h001101B3, 32'h108);
        settle();
        check("lw_add_stall", 32'(in_ready), 32'd0);
        tick();
        check("bubble_valid", 32'(out_valid), 32'd0);
        check("bubble_exe", 32'(out_exe_fun), 32'd0);
        check("bubble_rf_wen", 32'(out_rf_wen), 32'd0);
        check("after_bubble_ready", 32'(in_ready), 32'd1);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_rs1", 32'(out_rs1_addr), 32'd2);
        check("add_rs2", 32'(out_rs2_addr), 32'd1);
        check("add_rd", 32'(out_rd_addr), 32'd3);
        check("add_rs2_sel", 32'(out_rs2_sel), 32'd1);
        check("add_pc", out_pc, 32'h108);

        // LBU x5,-1(x0), then SH x5,4(x0) which depends on it through rs2
        send(32'hFFF04283, 32'h10C);
        tick();
        check("lbu_size", 32'(out_mem_size), 32'd0);
        check("lbu_unsigned", 32'(out_mem_unsigned), 32'd1);
        check("lbu_imm", out_imm, 32'hFFFFFFFF);
        check("lbu_wb", 32'(out_wb_sel), 32'd2);
        send(32'h00501223, 32'h110);
        settle();
        check("sh_rs2_stall", 32'(in_ready), 32'd0);
        tick();
        check("sh_bubble", 32'(out_valid), 32'd0);
        tick();
        check("sh_valid", 32'(out_valid), 32'd1);
        check("sh_size", 32'(out_mem_size), 32'd1);
        check("sh_mem_wen", 32'(out_mem_wen), 32'd1);
        check("sh_imm", out_imm, 32'd4);
        check("sh_rf_wen", 32'(out_rf_wen), 32'd0);
        check("sh_rs2_sel", 32'(out_rs2_sel), 32'd3);

        // Undefined opcode
        send(32'h0000007F, 32'h114);
        tick();
        check("ill_op_valid", 32'(out_valid), 32'd1);
        check("ill_op_flag", 32'(out_illegal), 32'd1);
        check("ill_op_ctrl", {29'd0, out_rf_wen, out_mem_wen, 1'b0}, 32'd0);
        check("ill_op_exe", 32'(out_exe_fun), 32'd0);

        // SLLI with funct7=0100000
        send(32'h40109093, 32'h118);
        tick();
        check("ill_slli_valid", 32'(out_valid), 32'd1);
        check("ill_slli_flag", 32'(out_illegal), 32'd1);
        check("ill_slli_rf_wen", 32'(out_rf_wen), 32'd0);
        check("ill_slli_mem_wen", 32'(out_mem_wen), 32'd0);

        // SRAI x1,x1,1 is legal with the same funct7
        send(32'h4010D093, 32'h11C);
        tick();
        check("srai_illegal", 32'(out_illegal), 32'd0);
        check("srai_exe", 32'(out_exe_fun), 32'd8);
        check("srai_imm", out_imm, 32'h401);

        // Downstream stall for 3 cycles with ADDI x4,x0,7 waiting
        out_ready = 1'b0;
        send(32'h00700213, 32'h120);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_hold_exe", 32'(out_exe_fun), 32'd8);
            check("stall_hold_pc", out_pc, 32'h11C);
        end
        out_ready = 1'b1;
        settle();
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("resume_rd", 32'(out_rd_addr), 32'd4);
        check("resume_imm", out_imm, 32'd7);
        in_valid = 1'b0;
        tick();
        check("no_dup_valid", 32'(out_valid), 32'd0);

        // BEQ x1,x2,8
        send(32'h00208463, 32'h200);
        tick();
        check("beq_exe", 32'(out_exe_fun), 32'd11);
        check("beq_imm", out_imm, 32'd8);
        check("beq_sel", {27'd0, out_rs1_sel, out_rs2_sel}, {27'd0, 2'd1, 3'd1});
        check("beq_rf_wen", 32'(out_rf_wen), 32'd0);

        // JAL x1,16
        send(32'h010000EF, 32'h204);
        tick();
        check("jal_imm", out_imm, 32'd16);
        check("jal_sel", {27'd0, out_rs1_sel, out_rs2_sel}, {27'd0, 2'd2, 3'd4});
        check("jal_wb", 32'(out_wb_sel), 32'd3);

        // LUI x8,0x12345
        send(32'h12345437, 32'h208);
        tick();
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_sel", {27'd0, out_rs1_sel, out_rs2_sel}, {27'd0, 2'd0, 3'd5});

        // FENCE decodes as a legal no-op
        send(32'h0000000F, 32'h20C);
        tick();
        check("fence_valid", 32'(out_valid), 32'd1);
        check("fence_illegal", 32'(out_illegal), 32'd0);
        check("fence_ctrl", {25'd0, out_exe_fun, out_rf_wen, out_mem_wen}, 32'd0);

        // Flush with a valid output and a valid input
        send(32'h00900313, 32'h300);
        tick();
        check("pre_flush_rd", 32'(out_rd_addr), 32'd6);
        flush = 1'b1;
        send(32'h00100393, 32'h304);
        settle();
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rd", 32'(out_rd_addr), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a downstream stall
        send(32'h00900313, 32'h308);
        tick();
        out_ready = 1'b0;
        send(32'h00100393, 32'h30C);
        settle();
        check("pre_rst_stall", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_rd", 32'(out_rd_addr), 32'd0);
        #1 rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        check("post_rst_capture", 32'(out_rd_addr), 32'd7);
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();

        // Interlock disabled: LW then dependent ADD flow back to back
        in_valid_b = 1'b1;
        in_inst = 32'h0000A103;
        in_pc = 32'h400;
        settle();
        check("nohaz_lw_ready", 32'(in_ready_b), 32'd1);
        tick();
        check("nohaz_lw_valid", 32'(out_valid_b), 32'd1);
        in_inst = 32'h001101B3;
        in_pc = 32'h404;
        settle();
        check("nohaz_add_ready", 32'(in_ready_b), 32'd1);
        tick();
        check("nohaz_add_valid", 32'(out_valid_b), 32'd1);
        check("nohaz_add_rd", 32'(out_rd_addr_b), 32'd3);
        check("nohaz_add_rs1", 32'(out_rs1_addr_b), 32'd2);
        in_valid_b = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
